seg7_display_scanner: RTL and testbench

Upstream feeder for the 4-digit seven-segment decimal decoder. Accepts a 16-bit binary value on a load strobe and converts it serially to four BCD digits, saturating to 9999 with an overflow flag. Time-multiplexes the digits, driving the decoder's 2-bit digit select, 4-bit digit code and decimal-point inputs at a programmable refresh rate.

---
 rtl/seg7_display_scanner_pkg.sv | 35 +++
 rtl/seg7_display_scanner_if.sv | 30 +++
 rtl/seg7_display_scanner_bin2bcd_serial.sv | 61 ++++++
 rtl/seg7_display_scanner.sv | 129 ++++++++++++
 tb/tb_seg7_display_scanner.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seg7_display_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg7_pkg                                               |
// | Description : Shared constants, types and helpers for the scanner.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package seg7_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_W     = 4;
  localparam int IDX_W       = 2;
  localparam int MAX_DECIMAL = 9999;
  localparam int CONV_ITERS  = 16;
  localparam int BIN_W       = 16;
  localparam int BCD_W       = 20;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_vec_t;

  // Display pattern used when the converted value saturates.
  localparam digit_vec_t SAT_DIGITS = {4'(MAX_DECIMAL / 1000 % 10),
                                       4'(MAX_DECIMAL / 100 % 10),
                                       4'(MAX_DECIMAL / 10 % 10),
                                       4'(MAX_DECIMAL % 10)};

  function automatic logic [DIGIT_W-1:0] bcd_adjust(input logic [DIGIT_W-1:0] col);
    return (col >= 4'd5) ? col + 4'd3 : col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_display_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg7_display_scanner_if                                |
// | Description : Load bus and decoder-side outputs of the scanner.      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface seg7_display_scanner_if;
  import seg7_pkg::*;

  logic [BIN_W-1:0]      value;
  logic                  load;
  logic [NUM_DIGITS-1:0] dot_mask;
  logic                  busy;
  logic                  overflow;
  logic [IDX_W-1:0]      seg_select;
  logic [DIGIT_W-1:0]    bin;
  logic                  dot;

  modport master (
    output value, load, dot_mask,
    input  busy, overflow, seg_select, bin, dot
  );

  modport slave (
    input  value, load, dot_mask,
    output busy, overflow, seg_select, bin, dot
  );

endinterface
`default_nettype wire

// File: rtl/seg7_display_scanner_bin2bcd_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bin2bcd_serial                                         |
// | Description : Serial double-dabble, one shift per cycle, 16 steps.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module bin2bcd_serial
  import seg7_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic [BIN_W-1:0] bin,
  output logic                  done,
  output logic [BCD_W-1:0]      bcd
);

  localparam int              CNT_W    = $clog2(CONV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_ITERS - 1);

  logic [BIN_W-1:0]       r_bin;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_active;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+BIN_W-1:0] w_shift;

  generate
    for (genvar c = 0; c < BCD_W / DIGIT_W; c++) begin : g_col
      assign w_adj[c*DIGIT_W +: DIGIT_W] = bcd_adjust(r_bcd[c*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  assign w_shift = {w_adj, r_bin} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_bin    <= bin;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      {r_bcd, r_bin} <= w_shift;
      r_cnt          <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_active <= 1'b0;
      end
    end
  end

  // High in the cycle whose closing edge performs the final shift.
  assign done = r_active && (r_cnt == CNT_LAST);
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg7_display_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg7_display_scanner                                   |
// | Description : Binary-to-BCD loader and 4-digit scan driver.          |
// |               BCD_CONVERT_EN selects decimal conversion; otherwise   |
// |               the loaded value is shown as four hex digits.          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module seg7_display_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
)
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  seg7_display_scanner_if.slave  bus
);

  localparam int                 PRESC_W    = $clog2(REFRESH_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  logic [PRESC_W-1:0]    r_presc;
  logic [IDX_W-1:0]      r_index;
  logic [DIGIT_W-1:0]    r_bin;
  logic                  r_dot;
  digit_vec_t            r_digits;
  logic [NUM_DIGITS-1:0] r_dots;
  logic                  w_tick;
  logic [IDX_W-1:0]      w_index_next;

  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_index_next = w_tick ? r_index + 1'b1 : r_index;

  // Output register follows the index being entered, so a digit update on
  // the same edge as an index advance shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_index <= '0;
      r_bin   <= '0;
      r_dot   <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_index <= w_index_next;
      r_bin   <= r_digits[w_index_next];
      r_dot   <= r_dots[w_index_next];
    end
  end

  assign bus.seg_select = r_index;
  assign bus.bin        = r_bin;
  assign bus.dot        = r_dot;

`ifdef BCD_CONVERT_EN
  logic [1:0]            r_state;
  logic [NUM_DIGITS-1:0] r_dot_pend;
  logic                  r_overflow;
  logic                  w_start;
  logic                  w_done;
  logic [BCD_W-1:0]      w_bcd;

  assign w_start = (r_state == ST_IDLE) && bus.load;

  bin2bcd_serial u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (bus.value),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dot_pend <= '0;
      r_overflow <= 1'b0;
      r_digits   <= '0;
      r_dots     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            r_dot_pend <= bus.dot_mask;
            r_state    <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (w_done) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // A non-zero fifth column means the value exceeds four digits.
          if (w_bcd[BCD_W-1 -: DIGIT_W] != '0) begin
            r_digits   <= SAT_DIGITS;
            r_overflow <= 1'b1;
          end else begin
            r_digits   <= w_bcd[BIN_W-1:0];
            r_overflow <= 1'b0;
          end
          r_dots  <= r_dot_pend;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.overflow = r_overflow;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_dots   <= '0;
    end else if (bus.load) begin
      r_digits <= bus.value;
      r_dots   <= bus.dot_mask;
    end
  end

  assign bus.busy     = 1'b0;
  assign bus.overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_scanner.sv
`default_nettype none
// Bench for seg7_display_scanner: directed and random loads compared every
// cycle against a digit-level reference model (decimal or hex per build).
module tb_seg7_display_scanner;

  localparam int REFRESH_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seg7_display_scanner_if bus();

  seg7_display_scanner #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs after each rising edge.
  int m_edges     = 0;
  int m_digits[4] = '{0, 0, 0, 0};
  bit m_dots[4]   = '{0, 0, 0, 0};
  bit m_pending   = 0;
  bit m_ovf       = 0;
  int m_sel       = 0;
  int m_bin       = 0;
  bit m_dot       = 0;
`ifdef BCD_CONVERT_EN
  int       m_accept = 0;
  int       m_val    = 0;
  bit [3:0] m_pdots  = '0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges   = 0;
      m_pending = 0;
      m_ovf     = 0;
      m_sel     = 0;
      m_bin     = 0;
      m_dot     = 0;
      for (int i = 0; i < 4; i++) begin
        m_digits[i] = 0;
        m_dots[i]   = 0;
      end
    end else begin
`ifdef BCD_CONVERT_EN
      bit was_pending;
      int v;
      was_pending = m_pending;
`endif
      m_edges = m_edges + 1;
      m_sel   = (m_edges / REFRESH_DIV) % 4;
      m_bin   = m_digits[m_sel];
      m_dot   = m_dots[m_sel];
`ifdef BCD_CONVERT_EN
      if (m_pending && m_edges == m_accept + 17) begin
        v = m_val;
        for (int i = 0; i < 4; i++) begin
          m_digits[i] = (m_val > 9999) ? 9 : v % 10;
          v = v / 10;
          m_dots[i] = m_pdots[i];
        end
        m_ovf     = (m_val > 9999);
        m_pending = 0;
      end
      if (!was_pending && bus.load) begin
        m_pending = 1;
        m_accept  = m_edges;
        m_val     = int'(bus.value);
        m_pdots   = bus.dot_mask;
      end
`else
      if (bus.load) begin
        for (int i = 0; i < 4; i++) begin
          m_digits[i] = int'(bus.value >> (4 * i)) & 15;
          m_dots[i]   = bus.dot_mask[i];
        end
      end
`endif
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sel"},  16'(bus.seg_select), 16'(m_sel));
    check({tag, ".bin"},  16'(bus.bin),        16'(m_bin));
    check({tag, ".dot"},  16'(bus.dot),        16'(m_dot));
    check({tag, ".busy"}, 16'(bus.busy),       16'(m_pending));
    check({tag, ".ovf"},  16'(bus.overflow),   16'(m_ovf));
  endtask

  task automatic tick(input string tag, input logic ld, input logic [15:0] v, input logic [3:0] dm);
    bus.load     = ld;
    bus.value    = v;
    bus.dot_mask = dm;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(tag, 1'b0, 16'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dot_mask = '0;

    @(negedge clk);
    check_all("reset");
    check("reset.sel0", 16'(bus.seg_select), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("scan", 18);

    // Asynchronous reset in the middle of a clock phase
    #2 rst_n = 1'b0;
    #1 check_all("async_rst");
    check("async_rst.bin0", 16'(bus.bin), 16'd0);
    @(negedge clk);
    check_all("in_rst");
    rst_n = 1'b1;
    idle("rescan", 17);

    tick("ld1234", 1'b1, 16'd1234, 4'b0010);
    idle("run1234", 40);
    tick("ld12345", 1'b1, 16'd12345, 4'b0000);
    idle("run12345", 30);
    tick("ld0", 1'b1, 16'd0, 4'b1111);
    idle("run0", 30);

    tick("ld65535", 1'b1, 16'd65535, 4'b1000);
    idle("busy65535", 4);
    tick("ld42_busy", 1'b1, 16'd42, 4'b0001);
    idle("run65535", 35);

    tick("ld1234b", 1'b1, 16'd1234, 4'b0000);
    idle("run1234b", 20);
    tick("ld5678", 1'b1, 16'd5678, 4'b0101);
    idle("conv5678", 8);
    #2 rst_n = 1'b0;
    #1 check_all("rst_conv");
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_rst", 30);

    tick("ldBEEF", 1'b1, 16'hBEEF, 4'b1001);
    idle("runBEEF", 20);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      tick("rnd_ld", 1'b1, v, 4'($urandom));
      idle("rnd", int'($urandom_range(0, 24)));
    end
    idle("tail", 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
